// File: rtl/usb_phy_tx_if.sv
// usb_phy_tx_if -- byte stream from the USB link layer into the PHY transmitter.
//   tx_lp_sop    : first byte (PID) of a packet
//   tx_lp_eop    : last byte of a packet
//   tx_lp_valid  : data/sop/eop valid this cycle
//   tx_lp_data   : packet byte, sent LSB first
//   tx_lp_cancle : abort the packet in flight
//   tx_lp_ready  : PHY can take a byte (accepted on valid && ready)
interface usb_phy_tx_if;
  logic       tx_lp_sop;
  logic       tx_lp_eop;
  logic       tx_lp_valid;
  logic [7:0] tx_lp_data;
  logic       tx_lp_cancle;
  logic       tx_lp_ready;

  modport master (
    output tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_data, tx_lp_cancle,
    input  tx_lp_ready
  );

  modport slave (
    input  tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_data, tx_lp_cancle,
    output tx_lp_ready
  );
endinterface

// File: rtl/usb_phy_tx.sv
// usb_phy_tx -- full-speed USB transmit PHY: SYNC generation, NRZI encoding,
// bit stuffing and EOP signalling from a byte stream.
//   clk         : single clock, rising edge
//   rst         : asynchronous active-high reset
//   lp          : usb_phy_tx_if.slave byte stream from the link
//   dp, dn      : line drive values (J = 1/0, K = 0/1, SE0 = 0/0)
//   d_oe        : line driver enable, high while a packet is on the wire
//   tx_underrun : one-cycle pulse when a packet is aborted for lack of data
//
// state | meaning
// IDLE  | line J, driver off, waiting for a sop byte
// SYNC  | sending the 0x80 sync pattern (KJKJKJKK)
// DATA  | sending packet bytes, NRZI + bit stuffing
// EOP   | SE0 for two bit times, then J for one bit time
module usb_phy_tx #(
  parameter int CLK_PER_BIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  usb_phy_tx_if.slave    lp,
  output logic           dp,
  output logic           dn,
  output logic           d_oe,
  output logic           tx_underrun
);

  localparam int TW = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  timer;
  logic           line_j;
  logic [7:0]     shift_reg;
  logic [3:0]     shift_cnt;
  logic           shift_eop;
  logic [7:0]     hold_reg;
  logic           hold_full;
  logic           hold_eop;
  logic [2:0]     ones_cnt;
  logic [1:0]     eop_cnt;
  logic           cancel_pend;
  logic           rdy_en;

  logic bit_tick, accept, in_pkt, cancel_now;
  logic start, do_stuff, do_shift, do_load, go_eop, do_underrun;
  logic emit, emit_bit, hold_wr, cancel_set;

  // rdy_en keeps ready low through reset and for the cycle it is released
  assign lp.tx_lp_ready = rdy_en && !hold_full && (state != EOP);

  assign accept     = lp.tx_lp_valid && lp.tx_lp_ready;
  assign in_pkt     = (state == SYNC) || (state == DATA);
  assign bit_tick   = (state != IDLE) && (timer == '0);
  assign cancel_now = cancel_pend || (lp.tx_lp_cancle && in_pkt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next bit is chosen at each bit boundary: a pending stuff bit beats
  // everything but cancel, the holding byte is only pulled once the
  // shifter is fully drained.
  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    do_stuff    = 1'b0;
    do_shift    = 1'b0;
    do_load     = 1'b0;
    go_eop      = 1'b0;
    do_underrun = 1'b0;
    dp          = 1'b1;
    dn          = 1'b0;
    d_oe        = 1'b0;
    case (state)
      IDLE: begin
        // a sop byte arriving together with cancel is dropped
        if (accept && lp.tx_lp_sop && !lp.tx_lp_cancle) begin
          start     = 1'b1;
          state_nxt = SYNC;
        end
      end
      SYNC, DATA: begin
        dp   = line_j;
        dn   = ~line_j;
        d_oe = 1'b1;
        if (bit_tick) begin
          if (cancel_now)              go_eop = 1'b1;
          else if (ones_cnt == 3'd6)   do_stuff = 1'b1;
          else if (shift_cnt != 4'd0)  do_shift = 1'b1;
          else if (shift_eop)          go_eop = 1'b1;
          else if (hold_full) begin
            do_load   = 1'b1;
            state_nxt = DATA;
          end else begin
            go_eop      = 1'b1;
            do_underrun = 1'b1;
          end
          if (go_eop) state_nxt = EOP;
        end
      end
      EOP: begin
        d_oe = 1'b1;
        dp   = (eop_cnt == 2'd2);
        dn   = 1'b0;
        if (bit_tick && eop_cnt == 2'd2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign emit       = do_stuff || do_shift || do_load;
  assign emit_bit   = do_stuff ? 1'b0 : (do_shift ? shift_reg[0] : hold_reg[0]);
  assign hold_wr    = accept && (state == DATA) && !cancel_now && !go_eop;
  assign cancel_set = lp.tx_lp_cancle && in_pkt && !go_eop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      line_j      <= 1'b1;
      shift_reg   <= 8'h00;
      shift_cnt   <= 4'd0;
      shift_eop   <= 1'b0;
      hold_reg    <= 8'h00;
      hold_full   <= 1'b0;
      hold_eop    <= 1'b0;
      ones_cnt    <= 3'd0;
      eop_cnt     <= 2'd0;
      cancel_pend <= 1'b0;
      rdy_en      <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rdy_en      <= 1'b1;
      tx_underrun <= do_underrun;

      if (state != IDLE) timer <= bit_tick ? TMR_LOAD : timer - TW'(1);

      // The first sync bit (a 0, so K) goes on the line right away; the
      // shifter keeps the other seven sync bits and the PID waits in hold.
      if (start) begin
        timer       <= TMR_LOAD;
        line_j      <= 1'b0;
        ones_cnt    <= 3'd0;
        shift_reg   <= 8'h40;
        shift_cnt   <= 4'd7;
        shift_eop   <= 1'b0;
        hold_reg    <= lp.tx_lp_data;
        hold_full   <= 1'b1;
        hold_eop    <= lp.tx_lp_eop;
        cancel_pend <= 1'b0;
      end

      if (emit) begin
        if (!emit_bit) begin
          line_j   <= ~line_j;
          ones_cnt <= 3'd0;
        end else begin
          ones_cnt <= ones_cnt + 3'd1;
        end
      end

      if (do_shift) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
        shift_cnt <= shift_cnt - 4'd1;
      end

      if (do_load) begin
        shift_reg <= {1'b0, hold_reg[7:1]};
        shift_cnt <= 4'd7;
        shift_eop <= hold_eop;
        hold_full <= 1'b0;
      end

      if (hold_wr) begin
        hold_reg  <= lp.tx_lp_data;
        hold_full <= 1'b1;
        hold_eop  <= lp.tx_lp_eop;
      end

      if (cancel_set) cancel_pend <= 1'b1;

      if (go_eop) begin
        hold_full   <= 1'b0;
        shift_cnt   <= 4'd0;
        shift_eop   <= 1'b0;
        cancel_pend <= 1'b0;
        ones_cnt    <= 3'd0;
        eop_cnt     <= 2'd0;
      end

      if (state == EOP && bit_tick) begin
        if (eop_cnt == 2'd2) begin
          eop_cnt <= 2'd0;
          line_j  <= 1'b1;
        end else begin
          eop_cnt <= eop_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: doc/usb_phy_tx.md
USB_PHY_TX -- requirements
Module: usb_phy_tx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 4, meaning clk cycles per USB bit time (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tx_lp_sop  input  1  marks the first byte (PID) of a packet from usb_link.
REQ-005 SHALL have port tx_lp_eop  input  1  marks the last byte of a packet.
REQ-006 SHALL have port tx_lp_valid  input  1  tx_lp_data/sop/eop are valid this cycle.
REQ-007 SHALL have port tx_lp_data  input  8  packet byte, transmitted LSB first.
REQ-008 SHALL have port tx_lp_cancle  input  1  abort the current packet.
REQ-009 SHALL have port tx_lp_ready  output  1  byte is accepted when tx_lp_valid && tx_lp_ready are both high.
REQ-010 SHALL have port dp  output  1  D+ line drive value.
REQ-011 SHALL have port dn  output  1  D- line drive value.
REQ-012 SHALL have port d_oe  output  1  line driver enable, high while a packet is on the wire.
REQ-013 SHALL have port tx_underrun  output  1  one-cycle pulse when the packet is aborted for lack of data.

Function
REQ-014 SHALL encode line states at full speed as follows: J = dp1/dn0, K = dp0/dn1, SE0 = dp0/dn0; idle drive = J with d_oe=0.
REQ-015 SHALL hold a bit-timer 0..CLK_PER_BIT-1; each bit is held for exactly CLK_PER_BIT cycles; the timer runs only outside IDLE.
REQ-016 SHALL implement FSM states IDLE, SYNC, DATA, EOP.
REQ-017 SHALL transition IDLE->SYNC on accepting a byte with tx_lp_sop=1; in IDLE, bytes without sop SHALL be accepted and discarded.
REQ-018 SHALL drive d_oe=1 and the first SYNC bit (K) in the cycle after the sop byte is accepted.
REQ-019 SHALL send SYNC as 8 bits of pattern 0x80 LSB first, giving KJKJKJKK on the line.
REQ-020 SHALL, in SYNC->DATA and DATA, NRZI-encode bits: a 0 toggles the line, a 1 holds it.
REQ-021 SHALL maintain a ones counter that starts at SYNC, clears on any 0 (including stuffed bits), and increments on each 1; on reaching 6 it SHALL insert one stuffed 0 bit before the next data bit, including after the last data bit before EOP.
REQ-022 SHALL have a 1-byte holding register plus an 8-bit shift register; tx_lp_ready = holding register empty and state is not EOP.
REQ-023 SHALL move holding->shift at the bit boundary after the 8th data bit; the next byte therefore follows with no gap.
REQ-024 SHALL, after shifting out the byte flagged eop (plus any stuffed bit), go to EOP: SE0 for 2 bit times, then J for 1 bit time, then IDLE with d_oe=0.
REQ-025 SHALL, if the shift register empties in DATA with the holding register empty and eop not yet seen, pulse tx_underrun and go to EOP.
REQ-026 SHALL, when tx_lp_cancle=1 in SYNC or DATA, complete the current bit, flush both registers, and go to EOP; cancle in IDLE or EOP has no effect.
REQ-027 SHALL NOT accept new bytes in EOP; it returns to IDLE and accepts the next sop one cycle after d_oe falls.
REQ-028 SHALL, on simultaneous cancle and byte acceptance, discard the byte.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, dp=1, dn=0, d_oe=0, tx_lp_ready=0, tx_underrun=0, clear all registers and counters; tx_lp_ready SHALL rise on the first clk edge after rst deasserts.
REQ-030 SHALL, when rst asserts mid-packet, immediately drop d_oe with no EOP.

Verification
REQ-031 SHALL verify: single byte 0xD2 with sop=eop=1, CLK_PER_BIT=4 -> KJKJKJKK, JJKJJKKK, SE0 SE0 J; d_oe high for exactly 76 cycles.
REQ-032 SHALL verify: bytes 0xC3,0xFF,0xFF streamed back-to-back -> stuffed 0 inserted after each run of six 1s (count including the trailing SYNC 1); no gaps between bytes; tx_lp_ready high 1 cycle per byte.
REQ-033 SHALL verify: sop byte 0xC3, then valid withheld -> tx_underrun pulses once after 8 data bits, then EOP follows and d_oe falls.
REQ-034 SHALL verify: tx_lp_cancle pulsed mid-DATA -> current bit completes, SE0 SE0 J, IDLE; a following packet transmits correctly.
REQ-035 SHALL verify: rst asserted during SYNC -> d_oe=0, dp=1, dn=0 asynchronously; tx_lp_ready=1 one cycle after release.
REQ-036 SHALL verify: CLK_PER_BIT=2 with 0xD2 -> same line sequence, d_oe high 38 cycles.
